// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared state encoding and round-robin helpers for the bus arbiter
package bus_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, OWNED, GAP} state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } sel_t;

    localparam int MAX_CORES = 16;

    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // first set bit of rq searching cyclically from ptr+1 over n cores
    function automatic sel_t rr_select(input logic [MAX_CORES-1:0] rq, input logic [3:0] ptr, input int n);
        sel_t       s;
        logic [3:0] k;
        s = '0;
        for (int i = 1; i <= MAX_CORES; i++) begin
            if (i <= n) begin
                k = 4'((int'(ptr) + i) % n);
                if (rq[k] && !s.found) begin
                    s.found = 1'b1;
                    s.idx   = k;
                end
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/bus_arbiter_channel.sv
// bus_arbiter_channel: round-robin arbiter with bounded-burst preemption for one bus
module bus_arbiter_channel
    import bus_arbiter_pkg::*;
#(
    parameter int N_CORES   = 4,
    parameter int MAX_BURST = 4,
    parameter int OWNER_W   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_CORES-1:0] rq,
    input  logic               ready,
    output logic [N_CORES-1:0] grant,
    output logic [OWNER_W-1:0] owner,
    output logic               owner_valid
);

    localparam int CNT_W = clog2(MAX_BURST + 1);

    state_t               state, state_n;
    logic [N_CORES-1:0]   grant_n;
    logic [OWNER_W-1:0]   owner_n, ptr, ptr_n;
    logic [CNT_W-1:0]     count, count_n;
    logic [MAX_CORES-1:0] rq_ext;
    sel_t                 sel;
    logic                 others, burst_done;

    assign owner_valid = (state == OWNED);

    // state, grant, owner, pointer and beat counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            ptr   <= OWNER_W'(N_CORES - 1);
            count <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            count <= count_n;
        end
    end

    // next-state: grant on request, release on drop, preempt on a completing beat
    always_comb begin
        rq_ext              = '0;
        rq_ext[N_CORES-1:0] = rq;
        sel                 = rr_select(rq_ext, 4'(ptr), N_CORES);
        others              = |(rq & ~grant);
        burst_done          = (MAX_BURST > 0) && ready && (int'(count) + 1 >= MAX_BURST);
        state_n             = state;
        grant_n             = grant;
        owner_n             = owner;
        ptr_n               = ptr;
        count_n             = count;
        case (state)
            OWNED: begin
                count_n = (ready && int'(count) < MAX_BURST) ? count + 1'b1 : count;
                if (!rq[owner] || (burst_done && others)) begin
                    state_n = GAP;
                    grant_n = '0;
                end
            end
            IDLE, GAP: begin
                state_n = sel.found ? OWNED : IDLE;
                grant_n = sel.found ? N_CORES'(1) << sel.idx : '0;
                owner_n = sel.found ? OWNER_W'(sel.idx) : owner;
                ptr_n   = sel.found ? OWNER_W'(sel.idx) : ptr;
                count_n = '0;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: independent data and instruction bus arbiters for the multi-core system
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_CORES   = 4,
    parameter int MAX_BURST = 4,
    parameter int OWNER_W   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_CORES-1:0] D_Bus_RQ,
    input  logic               D_Bus_Ready,
    output logic [N_CORES-1:0] D_Bus_GRANT,
    output logic [OWNER_W-1:0] D_Owner,
    output logic               D_Owner_Valid,
    input  logic [N_CORES-1:0] I_Bus_RQ,
    input  logic               I_Bus_Ready,
    output logic [N_CORES-1:0] I_Bus_GRANT,
    output logic [OWNER_W-1:0] I_Owner,
    output logic               I_Owner_Valid
);

    bus_arbiter_channel #(.N_CORES(N_CORES), .MAX_BURST(MAX_BURST), .OWNER_W(OWNER_W)) d_chan (
        .clock       (clock),
        .reset       (reset),
        .rq          (D_Bus_RQ),
        .ready       (D_Bus_Ready),
        .grant       (D_Bus_GRANT),
        .owner       (D_Owner),
        .owner_valid (D_Owner_Valid)
    );

    bus_arbiter_channel #(.N_CORES(N_CORES), .MAX_BURST(MAX_BURST), .OWNER_W(OWNER_W)) i_chan (
        .clock       (clock),
        .reset       (reset),
        .rq          (I_Bus_RQ),
        .ready       (I_Bus_Ready),
        .grant       (I_Bus_GRANT),
        .owner       (I_Owner),
        .owner_valid (I_Owner_Valid)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized scoreboard bench for bus_arbiter with MAX_BURST=4 and MAX_BURST=0
module tb_bus_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] d_rq, i_rq;
    logic       d_rdy, i_rdy;
    logic [3:0] d_g4, i_g4, d_g0, i_g0;
    logic [1:0] d_o4, i_o4, d_o0, i_o0;
    logic       d_v4, i_v4, d_v0, i_v0;

    typedef struct packed {
        int          cyc;
        logic [27:0] v;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         st[4], own[4], ptr[4], cnt[4];
    int         mb[4] = '{4, 4, 0, 0};
    logic [27:0] act;

    always #5 clock = ~clock;

    bus_arbiter #(.N_CORES(4), .MAX_BURST(4), .OWNER_W(2)) dut (
        .clock(clock), .reset(reset),
        .D_Bus_RQ(d_rq), .D_Bus_Ready(d_rdy), .D_Bus_GRANT(d_g4), .D_Owner(d_o4), .D_Owner_Valid(d_v4),
        .I_Bus_RQ(i_rq), .I_Bus_Ready(i_rdy), .I_Bus_GRANT(i_g4), .I_Owner(i_o4), .I_Owner_Valid(i_v4)
    );

    bus_arbiter #(.N_CORES(4), .MAX_BURST(0), .OWNER_W(2)) dut0 (
        .clock(clock), .reset(reset),
        .D_Bus_RQ(d_rq), .D_Bus_Ready(d_rdy), .D_Bus_GRANT(d_g0), .D_Owner(d_o0), .D_Owner_Valid(d_v0),
        .I_Bus_RQ(i_rq), .I_Bus_Ready(i_rdy), .I_Bus_GRANT(i_g0), .I_Owner(i_o0), .I_Owner_Valid(i_v0)
    );

    assign act = {{i_g0, i_o0, i_v0}, {d_g0, d_o0, d_v0}, {i_g4, i_o4, i_v4}, {d_g4, d_o4, d_v4}};

    always @(posedge clock) cyc <= cyc + 1;

    // Reference: st 0=idle 1=owned 2=gap; the owner is granted until it drops or its burst is spent
    function automatic void model_step(input int c, input logic [3:0] rq, input logic rdy, input logic r);
        int nxt;
        nxt = -1;
        if (r) begin
            st[c] = 0; own[c] = 0; ptr[c] = 3; cnt[c] = 0;
        end else if (st[c] == 1) begin
            if (!rq[own[c]])
                st[c] = 2;
            else if (mb[c] > 0 && rdy && cnt[c] + 1 >= mb[c] && (rq & ~(4'b1 << own[c])) != 4'b0)
                st[c] = 2;
            else if (rdy && cnt[c] < mb[c])
                cnt[c]++;
        end else begin
            for (int i = 1; i <= 4; i++)
                if (nxt < 0 && rq[(ptr[c] + i) % 4]) nxt = (ptr[c] + i) % 4;
            if (nxt >= 0) begin
                st[c] = 1; own[c] = nxt; ptr[c] = nxt; cnt[c] = 0;
            end else
                st[c] = 0;
        end
    endfunction

    function automatic logic [6:0] exp_of(input int c);
        return {(st[c] == 1) ? 4'b1 << own[c] : 4'b0, 2'(own[c]), st[c] == 1};
    endfunction

    task automatic step(input logic r, input logic [3:0] drq, input logic drdy, input logic [3:0] irq, input logic irdy);
        exp_t e;
        reset = r; d_rq = drq; d_rdy = drdy; i_rq = irq; i_rdy = irdy;
        model_step(0, drq, drdy, r);
        model_step(1, irq, irdy, r);
        model_step(2, drq, drdy, r);
        model_step(3, irq, irdy, r);
        e.cyc = cyc + 1;
        e.v   = {exp_of(3), exp_of(2), exp_of(1), exp_of(0)};
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare every expectation whose edge has already happened
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (act[k*7 +: 7] !== e.v[k*7 +: 7]) begin
                    failures++;
                    $display("FAIL chan%0d cyc=%0d got grant=%b owner=%0d valid=%b want grant=%b owner=%0d valid=%b",
                             k, e.cyc, act[k*7+3 +: 4], act[k*7+1 +: 2], act[k*7],
                             e.v[k*7+3 +: 4], e.v[k*7+1 +: 2], e.v[k*7]);
                end
            end
        end
    end

    initial begin
        logic [3:0] drq, irq;
        for (int c = 0; c < 4; c++) begin
            st[c] = 0; own[c] = 0; ptr[c] = 3; cnt[c] = 0;
        end
        #1;
        repeat (3) step(1'b1, 4'b1111, 1'b0, 4'b1111, 1'b0);
        for (int n = 0; n < 12; n++) step(1'b0, 4'b1111, 1'b0, 4'b1111, 1'b0);
        repeat (3) step(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0);
        for (int n = 0; n < 24; n++) step(1'b0, 4'b1010, n[0], 4'b0000, 1'b0);
        repeat (6) step(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0);
        repeat (3) step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        repeat (4) step(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
        step(1'b1, 4'b0101, 1'b0, 4'b0101, 1'b0);
        repeat (3) step(1'b0, 4'b0101, 1'b0, 4'b0101, 1'b0);
        drq = 4'b0000;
        irq = 4'b0000;
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0) drq[b] = ~drq[b];
                if ($urandom_range(7) == 0) irq[b] = ~irq[b];
            end
            step($urandom_range(149) == 0, drq, 1'($urandom_range(1)), irq, 1'($urandom_range(1)));
        end
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
